// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment driver.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // Active-high gfedcba glyphs
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } slot_state_e;

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-high seven-segment glyph; letters only when hex_en is set.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex_en,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nib)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = hex_en ? SEG_A : SEG_BLANK;
      4'hB: seg_c = hex_en ? SEG_B : SEG_BLANK;
      4'hC: seg_c = hex_en ? SEG_C : SEG_BLANK;
      4'hD: seg_c = hex_en ? SEG_D : SEG_BLANK;
      4'hE: seg_c = hex_en ? SEG_E : SEG_BLANK;
      4'hF: seg_c = hex_en ? SEG_F : SEG_BLANK;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed common-anode seven-segment driver with a dead cycle per slot.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   hex_mode,
  output logic [6:0]             seg_n,
  output logic                   dp_n,
  output logic [NDIGITS-1:0]     an_n
);

  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned VAL_W = 4 * NDIGITS;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  slot_state_e        state_q, state_d;
  logic [VAL_W-1:0]   val_q, val_d;
  logic [NDIGITS-1:0] dp_q, dp_d;
  logic               hex_q, hex_d;
  seg_t               seg_n_q, seg_n_d;
  logic               dp_n_q, dp_n_d;
  logic [NDIGITS-1:0] an_n_q, an_n_d;

  logic               tick_c;
  logic [3:0]         nib_c;
  logic               dp_sel_c;
  logic               blank_c;
  logic [NDIGITS-1:0] an_drive_c;
  seg_t               glyph_c;

  // Select the current digit's nibble, dp bit, anode pattern and blanking
  always_comb begin
    nib_c      = 4'h0;
    dp_sel_c   = 1'b0;
    blank_c    = 1'b0;
    an_drive_c = '1;
    for (int unsigned k = 0; k < NDIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_c         = val_q[4*k +: 4];
        dp_sel_c      = dp_q[k];
        an_drive_c[k] = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        blank_c       = (k != 0) && ((val_q >> (4*k)) == '0);
`endif
      end
    end
  end

  seg_decode u_decode (
    .nib    (nib_c),
    .hex_en (hex_q),
    .seg_c  (glyph_c)
  );

  // Next-state and pin values; a tick always starts the next slot in DEAD
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    idx_d   = idx_q;
    state_d = DRIVE;
    val_d   = val_q;
    dp_d    = dp_q;
    hex_d   = hex_q;
    seg_n_d = ~SEG_BLANK;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    tick_c  = (div_q == DIV_W'(REFRESH_DIV - 1));

    if (tick_c) begin
      div_d   = '0;
      state_d = DEAD;
      idx_d   = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (load) begin
      val_d = value;
      dp_d  = dp_in;
      hex_d = hex_mode;
    end

    if (state_q == DRIVE) begin
      an_n_d  = an_drive_c;
      dp_n_d  = ~dp_sel_c;
      seg_n_d = blank_c ? ~SEG_BLANK : ~glyph_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      div_q   <= '0;
      idx_q   <= '0;
      state_q <= DEAD;
      val_q   <= '0;
      dp_q    <= '0;
      hex_q   <= 1'b0;
      seg_n_q <= ~SEG_BLANK;
      dp_n_q  <= 1'b1;
      an_n_q  <= '1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      hex_q   <= hex_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (NDIGITS=4, REFRESH_DIV=4).
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } pins_t;

  logic        clk;
  logic        n_reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        hex_mode;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  pins_t       exp_q[$];
  int          n_cmp;
  int          n_bad;
  int          cyc_no;

  // Reference state: cycles since reset and the shadow contents it should hold
  int          cnt;
  logic [15:0] mval;
  logic [3:0]  mdp;
  logic        mhex;

  seg_scan_driver #(.NDIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .hex_mode (hex_mode),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .an_n     (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hx);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
      4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
      4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
      4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
    endcase
    if (!hx && nib > 4'h9) g = 7'h00;
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d got %h exp %h", tag, cyc_no, got, exp);
    end
  endtask

  task automatic compare_pending();
    pins_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg_n", 32'(seg_n), 32'(e.seg));
      check("dp_n",  32'(dp_n),  32'(e.dp));
      check("an_n",  32'(an_n),  32'(e.an));
    end
  endtask

  // One clock: compare last edge, drive inputs, predict the coming edge
  task automatic cyc(input logic rn, input logic ld, input logic [15:0] v,
                     input logic [3:0] d, input logic hx);
    pins_t      e;
    int         p;
    int         dg;
    logic [3:0] one;
    logic [3:0] nib;
    @(negedge clk);
    cyc_no++;
    compare_pending();
    n_reset  = rn;
    load     = ld;
    value    = v;
    dp_in    = d;
    hex_mode = hx;
    if (!rn) begin
      e    = {7'h7F, 1'b1, 4'hF};
      cnt  = 0;
      mval = '0;
      mdp  = '0;
      mhex = 1'b0;
    end else begin
      p  = cnt % RD;
      dg = (cnt / RD) % ND;
      if (p == 0) begin
        e = {7'h7F, 1'b1, 4'hF};
      end else begin
        one   = 4'b0001;
        nib   = mval[4*dg +: 4];
        e.an  = ~(one << dg);
        e.dp  = ~mdp[dg];
        e.seg = ~glyph(nib, mhex);
`ifdef SEG_LZ_BLANK_EN
        if (dg > 0 && (mval >> (4*dg)) == 16'h0) e.seg = 7'h7F;
`endif
      end
      cnt++;
      if (ld) begin
        mval = v;
        mdp  = d;
        mhex = hx;
      end
    end
    exp_q.push_back(e);
  endtask

  // Idle cycle with junk on value to confirm shadows hold without load
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'(i * 16'h1111), 4'(i), i[0]);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc_no   = 0;
    cnt      = 0;
    mval     = '0;
    mdp      = '0;
    mhex     = 1'b0;
    n_reset  = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    hex_mode = 1'b0;

    repeat (3) cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(2);

    cyc(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    idle(20);

    cyc(1'b1, 1'b1, 16'hABCD, 4'h0, 1'b1);
    idle(18);
    cyc(1'b1, 1'b1, 16'hABCD, 4'h0, 1'b0);
    idle(18);

    for (int i = 0; i < RD && (cnt % RD) != RD - 1; i++) idle(1);
    cyc(1'b1, 1'b1, 16'h1234, 4'b0100, 1'b0);
    idle(18);

    cyc(1'b1, 1'b1, 16'h0050, 4'h0, 1'b0);
    idle(18);

    for (int i = 0; i < ND * RD && !(((cnt / RD) % ND) == 2 && (cnt % RD) == 2); i++) idle(1);
    cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 16'h0987, 4'b0001, 1'b0);
    idle(14);

    @(negedge clk);
    cyc_no++;
    compare_pending();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
